vga_layer_mixer: RTL and testbench

// - Parametrised pixel compositor between the game renderers and the VGA DAC pins.
// - Selects the highest-priority enabled layer from NUM_LAYERS RGB888 inputs, falling back to BG_COLOR.
// - Alpha-blends the result with a full-screen overlay, for example the game-over screen.
// - The overlay fades in and out over frames under a small FSM. Outputs are registered and blanked outside the active area.

---
 rtl/vga_layer_mixer.sv | 158 +++++++++++++++
 tb/tb_vga_layer_mixer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// Pixel compositor: priority-selects one of NUM_LAYERS RGB888 layers, alpha-blends it with a
// full-screen overlay whose opacity fades per frame, and drives registered, blanked VGA colour.
module vga_layer_mixer #(
    parameter int          NUM_LAYERS = 4,
    parameter int          ALPHA_W    = 4,
    parameter int          FADE_STEP  = 1,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter bit          VS_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              h_count,
    input  logic [9:0]              v_count,
    input  logic                    vsync,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic                    overlay_sel,
    input  logic [23:0]             overlay_rgb,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b,
    output logic                    fading,
    output logic                    overlay_full
);

    localparam int             AW       = ALPHA_W + 1;
    localparam int             PW       = 8 + ALPHA_W + 1;
    localparam logic [AW-1:0]  A_MAX    = AW'(2 ** ALPHA_W);
    localparam logic           VS_INACT = VS_ACT_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {ST_BASE, ST_FADE_IN, ST_SHOW, ST_FADE_OUT} state_t;

    // Truncating per-channel blend; alpha=0 yields b, alpha=A_MAX yields o exactly.
    function automatic logic [7:0] blend_ch(input logic [7:0] b, input logic [7:0] o,
                                            input logic [AW-1:0] a);
        logic [PW-1:0] p;
        p = PW'(b) * PW'(A_MAX - a) + PW'(o) * PW'(a);
        return 8'(p >> ALPHA_W);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] alpha_q, alpha_d, alpha_up_s, alpha_dn_s;
    logic [31:0]   up_sum_s;
    logic          vsync_q, vsync_d, armed_q, armed_d, tick_s;
    logic          fading_q, fading_d, full_q, full_d;
    logic [23:0]   base_q, base_d, ov_q, ov_d;
    logic          act_q, act_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;

    // Frame tick on the vsync edge into its active level; armed_q suppresses a tick at reset release.
    always_comb begin
        vsync_d = vsync;
        armed_d = 1'b1;
        tick_s  = armed_q && (vsync_q == VS_INACT) && (vsync != VS_INACT);
    end

    // Saturating alpha steps; FADE_STEP may exceed the full range.
    always_comb begin
        up_sum_s   = 32'(alpha_q) + 32'(FADE_STEP);
        alpha_up_s = (up_sum_s >= 32'(A_MAX)) ? A_MAX : AW'(up_sum_s);
        if (32'(alpha_q) <= 32'(FADE_STEP)) begin
            alpha_dn_s = {AW{1'b0}};
        end else begin
            alpha_dn_s = AW'(32'(alpha_q) - 32'(FADE_STEP));
        end
    end

    // Fade FSM: resolve overlay_sel first, then let a tick step alpha in the new direction.
    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        case (state_q)
            ST_BASE:     state_d = overlay_sel ? ST_FADE_IN : ST_BASE;
            ST_FADE_IN:  state_d = overlay_sel ? ST_FADE_IN : ST_FADE_OUT;
            ST_SHOW:     state_d = overlay_sel ? ST_SHOW : ST_FADE_OUT;
            ST_FADE_OUT: state_d = overlay_sel ? ST_FADE_IN : ST_FADE_OUT;
            default:     state_d = ST_BASE;
        endcase
        if (tick_s && (state_d == ST_FADE_IN)) begin
            alpha_d = alpha_up_s;
            state_d = (alpha_up_s == A_MAX) ? ST_SHOW : ST_FADE_IN;
        end else if (tick_s && (state_d == ST_FADE_OUT)) begin
            alpha_d = alpha_dn_s;
            state_d = (alpha_dn_s == {AW{1'b0}}) ? ST_BASE : ST_FADE_OUT;
        end else begin
            alpha_d = alpha_q;
        end
        fading_d = (state_d == ST_FADE_IN) || (state_d == ST_FADE_OUT);
        full_d   = (state_d == ST_SHOW);
    end

    // Stage 1: lowest enabled index wins, so scan from the top down and let later hits override.
    always_comb begin
        base_d = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i]) begin
                base_d = layer_rgb[24*i +: 24];
            end else begin
                base_d = base_d;
            end
        end
        ov_d  = overlay_rgb;
        act_d = ({22'd0, h_count} < 32'(H_ACTIVE)) && ({22'd0, v_count} < 32'(V_ACTIVE));
    end

    // Stage 2: blend with the frame-constant alpha and blank outside the visible area.
    always_comb begin
        if (act_q) begin
            r_d = blend_ch(base_q[23:16], ov_q[23:16], alpha_q);
            g_d = blend_ch(base_q[15:8],  ov_q[15:8],  alpha_q);
            b_d = blend_ch(base_q[7:0],   ov_q[7:0],   alpha_q);
        end else begin
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
        end
    end

    // State, alpha, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BASE;
            alpha_q  <= {AW{1'b0}};
            vsync_q  <= VS_INACT;
            armed_q  <= 1'b0;
            fading_q <= 1'b0;
            full_q   <= 1'b0;
            base_q   <= 24'd0;
            ov_q     <= 24'd0;
            act_q    <= 1'b0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
        end else begin
            state_q  <= state_d;
            alpha_q  <= alpha_d;
            vsync_q  <= vsync_d;
            armed_q  <= armed_d;
            fading_q <= fading_d;
            full_q   <= full_d;
            base_q   <= base_d;
            ov_q     <= ov_d;
            act_q    <= act_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign vga_r        = r_q;
    assign vga_g        = g_q;
    assign vga_b        = b_q;
    assign fading       = fading_q;
    assign overlay_full = full_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer: table vectors through a latency scoreboard,
// plus directed fade, reversal and reset sequences.
module tb_vga_layer_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_count, v_count;
    logic        vsync;
    logic [95:0] layer_rgb;
    logic [3:0]  layer_en;
    logic        overlay_sel;
    logic [23:0] overlay_rgb;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        fading, overlay_full;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vga_layer_mixer dut (
        .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count), .vsync(vsync),
        .layer_rgb(layer_rgb), .layer_en(layer_en), .overlay_sel(overlay_sel),
        .overlay_rgb(overlay_rgb), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .fading(fading), .overlay_full(overlay_full)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [3:0]  en;
        logic [95:0] layers;
        logic [23:0] ov;
        logic [23:0] exp_rgb;
    } vec_t;

    typedef struct {
        int          tag;
        logic [23:0] rgb;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare the output when the expected pixel's cycle arrives.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].tag == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, {8'd0, vga_r, vga_g, vga_b}, {8'd0, e.rgb});
        end
    end

    task automatic tick();
        @(negedge clk); vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; overlay_sel = 1'b0; vsync = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // White overlay over black background: expected red = 255*alpha >> 4.
    function automatic logic [31:0] fade_red(input int a);
        return 32'((255 * a) >> 4);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"prio_0110", 10'd0,   10'd0,   4'b0110, {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456}, 24'hA5A5A5, 24'hFF0000};
        vecs[1] = '{"prio_bg",   10'd5,   10'd5,   4'b0000, {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456}, 24'hFFFFFF, 24'h000000};
        vecs[2] = '{"blank_h",   10'd640, 10'd0,   4'b0001, {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}, 24'hFFFFFF, 24'h000000};
        vecs[3] = '{"blank_v",   10'd0,   10'd480, 4'b0001, {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}, 24'hFFFFFF, 24'h000000};
        vecs[4] = '{"edge_vis",  10'd639, 10'd479, 4'b0001, {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}, 24'h000000, 24'hFFFFFF};
        vecs[5] = '{"prio_l3",   10'd100, 10'd200, 4'b1000, {24'h123456, 24'h00FF00, 24'hFF0000, 24'hFFFFFF}, 24'h5A5A5A, 24'h123456};
        vecs[6] = '{"prio_all",  10'd1,   10'd2,   4'b1111, {24'h123456, 24'h00FF00, 24'hFF0000, 24'hABCDEF}, 24'h5A5A5A, 24'hABCDEF};
        vecs[7] = '{"prio_1100", 10'd300, 10'd300, 4'b1100, {24'h123456, 24'h00FF00, 24'hFF0000, 24'hABCDEF}, 24'h777777, 24'h00FF00};
        vecs[8] = '{"blank_max", 10'd1023,10'd1023,4'b0001, {24'h123456, 24'h00FF00, 24'hFF0000, 24'hABCDEF}, 24'h777777, 24'h000000};
        vecs[9] = '{"prio_1010", 10'd10,  10'd20,  4'b1010, {24'h123456, 24'h00FF00, 24'h3C3C3C, 24'hABCDEF}, 24'h777777, 24'h3C3C3C};

        rst_n = 1'b0; vsync = 1'b1; overlay_sel = 1'b0;
        h_count = 10'd0; v_count = 10'd0; layer_rgb = 96'd0; layer_en = 4'd0; overlay_rgb = 24'd0;

        // Reset held with toggling inputs
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            h_count = 10'($urandom); v_count = 10'($urandom); vsync = 1'($urandom);
            layer_rgb = {$urandom, $urandom, $urandom}; layer_en = 4'($urandom);
            overlay_sel = 1'($urandom); overlay_rgb = 24'($urandom);
            chk("rst_hold_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
            chk("rst_hold_flags", {30'd0, fading, overlay_full}, 32'd0);
        end

        // Release with vsync already active: no tick, alpha stays 0
        @(negedge clk);
        vsync = 1'b0; overlay_sel = 1'b1; layer_en = 4'd0; overlay_rgb = 24'hFFFFFF;
        h_count = 10'd0; v_count = 10'd0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("release_no_tick", {24'd0, vga_r}, 32'd0);
        chk("release_fading", {31'd0, fading}, 32'd1);
        @(negedge clk); vsync = 1'b1;
        repeat (2) @(negedge clk);
        tick();
        chk("first_tick_red", {24'd0, vga_r}, 32'h0F);

        // Table vectors at alpha=0 through the scoreboard
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            h_count = vecs[k].h; v_count = vecs[k].v; layer_en = vecs[k].en;
            layer_rgb = vecs[k].layers; overlay_rgb = vecs[k].ov;
            sb_q.push_back('{cyc + 2, vecs[k].exp_rgb, vecs[k].name});
        end
        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        // Full fade-in
        h_count = 10'd0; v_count = 10'd0; layer_en = 4'd0; overlay_rgb = 24'hFFFFFF;
        overlay_sel = 1'b1;
        @(negedge clk);
        chk("fadein_start", {31'd0, fading}, 32'd1);
        for (int a = 1; a <= 16; a++) begin
            tick();
            chk($sformatf("fadein_r_%0d", a), {24'd0, vga_r}, fade_red(a));
        end
        chk("fadein_spec_full", {24'd0, vga_r}, 32'hFF);
        chk("show_flags", {30'd0, fading, overlay_full}, 32'd1);
        tick();
        chk("show_hold", {24'd0, vga_r, vga_g, vga_b}, 32'hFFFFFF);

        // Reversal: up 5, down to BASE in 5 ticks
        do_reset();
        overlay_sel = 1'b1;
        ticks(5);
        chk("rev_up5", {24'd0, vga_r}, fade_red(5));
        overlay_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rev_keep5", {24'd0, vga_r}, fade_red(5));
        chk("rev_fading", {30'd0, fading, overlay_full}, 32'd2);
        tick();
        chk("rev_a4", {24'd0, vga_r}, fade_red(4));
        ticks(3);
        chk("rev_a1", {24'd0, vga_r}, fade_red(1));
        chk("rev_a1_fading", {31'd0, fading}, 32'd1);
        tick();
        chk("rev_base_r", {24'd0, vga_r}, 32'd0);
        chk("rev_base_flags", {30'd0, fading, overlay_full}, 32'd0);

        // Reversal again: resume fade-in from alpha 2
        overlay_sel = 1'b1;
        ticks(5);
        overlay_sel = 1'b0;
        ticks(3);
        chk("rev2_a2", {24'd0, vga_r}, fade_red(2));
        overlay_sel = 1'b1;
        repeat (2) @(negedge clk);
        chk("rev2_keep2", {24'd0, vga_r}, fade_red(2));
        chk("rev2_fading", {31'd0, fading}, 32'd1);
        tick();
        chk("rev2_a3", {24'd0, vga_r}, fade_red(3));

        // Asynchronous reset mid-fade at alpha 9
        do_reset();
        overlay_sel = 1'b1;
        ticks(9);
        chk("mid_a9", {24'd0, vga_r}, fade_red(9));
        #5 rst_n = 1'b0;
        #1;
        chk("async_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk("async_flags", {30'd0, fading, overlay_full}, 32'd0);
        overlay_sel = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_flags", {30'd0, fading, overlay_full}, 32'd0);
        tick();
        chk("post_rst_a0", {24'd0, vga_r}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
